pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register for the datapath. It carries a WIDTH-bit payload bundle between two stages using a valid/ready handshake instead of a global stall line. A two-entry skid buffer keeps `in_ready` purely registered, so back-pressure never forms a combinational path through the stage. It adds a synchronous flush and a saturating back-pressure counter for performance analysis, and is intended to replace per-field stall/flush register banks between IF/ID/EXE/MEM/WB.

---
 rtl/pipe_stage_skid.sv | 102 ++++++++++
 tb/tb_pipe_stage_skid.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Valid/ready pipeline stage with a two-entry skid buffer, a
//            synchronous flush and a saturating back-pressure counter.
// Revision : 1.0  initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic             r_m_v;
    logic [WIDTH-1:0] r_m_d;
    logic             r_s_v;
    logic [WIDTH-1:0] r_s_d;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_accept;
    logic w_pop;
    logic w_stall;

    // in_ready depends only on the skid flag, so out_ready never reaches it
    assign in_ready  = ~r_s_v;
    assign out_valid = r_m_v;
    assign out_data  = r_m_d;
    assign occupancy = {1'b0, r_m_v} + {1'b0, r_s_v};
    assign stall_cnt = r_stall_cnt;

    assign w_accept = in_valid & ~r_s_v;
    assign w_pop    = r_m_v & out_ready;
    assign w_stall  = r_m_v & ~out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_v       <= 1'b0;
            r_s_v       <= 1'b0;
            r_m_d       <= RESET_VAL;
            r_s_d       <= RESET_VAL;
            r_stall_cnt <= '0;
        end else begin
            // Counter sees the pre-flush state and is untouched by flush
            if (w_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            if (flush) begin
                r_m_v <= 1'b0;
                r_s_v <= 1'b0;
                r_m_d <= RESET_VAL;
                r_s_d <= RESET_VAL;
            end else begin
                case ({r_m_v, r_s_v})
                    2'b00: begin
                        if (w_accept) begin
                            r_m_v <= 1'b1;
                            r_m_d <= in_data;
                        end
                    end
                    2'b10: begin
                        if (w_pop && w_accept) begin
                            r_m_d <= in_data;
                        end else if (w_pop) begin
                            r_m_v <= 1'b0;
                        end else if (w_accept) begin
                            r_s_v <= 1'b1;
                            r_s_d <= in_data;
                        end
                    end
                    2'b11: begin
                        if (w_pop) begin
                            r_m_d <= r_s_d;
                            r_s_v <= 1'b0;
                        end
                    end
                    default: begin
                        // Skid-only is unreachable; fall back to empty
                        r_m_v <= 1'b0;
                        r_s_v <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Purpose  : Scoreboard bench for pipe_stage_skid (directed + random traffic).
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int          WIDTH     = 32;
    localparam int          CNT_W     = 4;
    localparam logic [31:0] RESET_VAL = 32'hDEAD_BEEF;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    pipe_stage_skid #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the stage is a FIFO of at most two payloads
    logic [31:0] exq[$];
    int          n_held   = 0;
    int          cnt      = 0;
    bit          rv_flag  = 1'b1;
    int          total    = 0;
    int          bad      = 0;
    int          delivered = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare on the falling edge, retire the head when it is taken
    always @(negedge clk) begin
        check("occupancy", 32'(occupancy), 32'(exq.size()));
        check("in_ready", 32'(in_ready), 32'(exq.size() < 2));
        check("out_valid", 32'(out_valid), 32'(exq.size() > 0));
        if (exq.size() > 0)
            check("out_data", out_data, exq[0]);
        else if (rv_flag)
            check("out_data_rstval", out_data, RESET_VAL);
        check("stall_cnt", 32'(stall_cnt), 32'(cnt));
        if (exq.size() > 0 && out_ready && !rst) begin
            void'(exq.pop_front());
            delivered++;
        end
    end

    // Advance one clock and update the model from the inputs applied this cycle
    task automatic tick();
        bit acc;
        bit pop;
        @(posedge clk);
        if (rst) begin
            exq.delete();
            n_held  = 0;
            cnt     = 0;
            rv_flag = 1'b1;
        end else begin
            if (n_held > 0 && !out_ready && cnt < CNT_MAX) cnt++;
            acc = in_valid && (n_held < 2);
            pop = (n_held > 0) && out_ready;
            if (flush) begin
                exq.delete();
                n_held  = 0;
                rv_flag = 1'b1;
            end else begin
                if (acc) begin
                    exq.push_back(in_data);
                    rv_flag = 1'b0;
                end
                n_held = n_held + int'(acc) - int'(pop);
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input bit rdy, input bit fl);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        flush     = fl;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        drive(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming
        drive(1'b1, 32'h1, 1'b1, 1'b0);
        drive(1'b1, 32'h2, 1'b1, 1'b0);
        drive(1'b1, 32'h3, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("stream_delivered", 32'(delivered), 32'd3);
        check("stream_stall", 32'(stall_cnt), 32'd0);

        // Skid: 0x10 and 0x11 captured, 0x12 held upstream
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        check("skid_full_ready", 32'(in_ready), 32'd0);
        check("skid_full_occ", 32'(occupancy), 32'd2);
        drive(1'b1, 32'h12, 1'b0, 1'b0);
        drive(1'b1, 32'h12, 1'b0, 1'b0);
        check("skid_stall", 32'(stall_cnt), 32'd3);
        drive(1'b1, 32'h12, 1'b1, 1'b0);
        drive(1'b1, 32'h12, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("skid_delivered", 32'(delivered), 32'd6);

        // Flush while FULL, with a payload offered in the same cycle
        drive(1'b1, 32'h20, 1'b0, 1'b0);
        drive(1'b1, 32'h21, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 1'b0, 1'b1);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);
        check("flush_stall_kept", 32'(stall_cnt), 32'd5);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("flush_nothing_out", 32'(delivered), 32'd6);

        // Counter saturation
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("sat_value", 32'(stall_cnt), 32'd15);
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("sat_cleared", 32'(stall_cnt), 32'd0);

        // Simultaneous pop and accept in ONE
        drive(1'b1, 32'h30, 1'b0, 1'b0);
        drive(1'b1, 32'h31, 1'b1, 1'b0);
        check("pa_data", out_data, 32'h31);
        check("pa_occ", 32'(occupancy), 32'd1);
        check("pa_ready", 32'(in_ready), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic with phases of varying back-pressure
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 500; i++) begin
                rst = ($urandom_range(0, 299) == 0);
                drive($urandom_range(0, 3) != 0, $urandom,
                      $urandom_range(0, 5) < (ph + 1),
                      $urandom_range(0, 39) == 0);
            end
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
